// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: sequences start, data, optional parity and stop bits around an
// external serializer that supplies the data bits LSB first.
module uart_tx_ctrl #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  DATA_VALID,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  ser_data,
   input  logic                  ser_done,
   output logic                  load,
   output logic                  ser_en,
   output logic                  TX_OUT,
   output logic                  Busy
);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } state_e;

   state_e state_q, state_d;
   logic   par_q;
   logic   par_en_q;

   // State register; parity settings are captured only when a request is accepted.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q  <= StIdle;
         par_q    <= 1'b0;
         par_en_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load) begin
            par_q    <= (^P_DATA) ^ PAR_TYP;
            par_en_q <= PAR_EN;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   state_d = DATA_VALID ? StStart : StIdle;
         StStart:  state_d = StData;
         StData: begin
            if (ser_done) begin
               state_d = par_en_q ? StParity : StStop;
            end
         end
         StParity: state_d = StStop;
         StStop:   state_d = DATA_VALID ? StStart : StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Requests are accepted only in IDLE or STOP, and never while reset is asserted.
   always_comb begin
      load   = 1'b0;
      ser_en = 1'b0;
      TX_OUT = 1'b1;
      Busy   = 1'b1;
      unique case (state_q)
         StIdle: begin
            Busy = 1'b0;
            load = DATA_VALID & RST;
         end
         StStart:  TX_OUT = 1'b0;
         StData: begin
            ser_en = 1'b1;
            TX_OUT = ser_data;
         end
         StParity: TX_OUT = par_q;
         StStop:   load = DATA_VALID & RST;
         default: begin
            Busy = 1'b0;
         end
      endcase
   end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the width of the parallel data word and the number of serialized data bits.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset, with ports in this order:
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  synchronous active-low reset.
REQ-003 It SHALL have these remaining ports:
- DATA_VALID  input  1  request to transmit P_DATA.
- P_DATA  input  DATA_WIDTH  parallel word, used for parity only.
- PAR_EN  input  1  1 = insert parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- ser_data  input  1  current data bit from the downstream serializer.
- ser_done  input  1  serializer's last-bit indication.
- load  output  1  serializer load strobe.
- ser_en  output  1  serializer shift enable.
- TX_OUT  output  1  UART line.
- Busy  output  1  frame in progress.

Function
REQ-004 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP, held in a state register.
REQ-005 In IDLE, TX_OUT SHALL be 1 and Busy SHALL be 0. When DATA_VALID=1, load SHALL be 1 combinationally in the same cycle, and the next state SHALL be START.
REQ-006 On every accepted request, the block SHALL register these values at the same edge: PAR_EN into par_en_q, and the parity bit par_q.
- par_q SHALL be the XOR-reduction of P_DATA when PAR_TYP=0.
- par_q SHALL be the inverted XOR-reduction of P_DATA when PAR_TYP=1.
REQ-007 START SHALL last exactly 1 cycle with TX_OUT=0, and the next state SHALL be DATA.
REQ-008 In DATA, ser_en SHALL be 1 and TX_OUT SHALL equal ser_data. The state SHALL remain DATA until ser_done=1, which gives exactly DATA_WIDTH cycles.
REQ-009 On ser_done=1 in DATA, the next state SHALL be PARITY if par_en_q=1, otherwise STOP.
REQ-010 PARITY SHALL last 1 cycle with TX_OUT=par_q, and the next state SHALL be STOP.
REQ-011 STOP SHALL last 1 cycle with TX_OUT=1.
- DATA_VALID=0: next state SHALL be IDLE.
- DATA_VALID=1: load SHALL be 1 in that cycle, parity SHALL be captured per REQ-006, and the next state SHALL be START (back-to-back frame, no idle gap).
REQ-012 Busy SHALL be 1 in every state except IDLE.
REQ-013 DATA_VALID SHALL be ignored in START, DATA and PARITY: no load, and no change to par_q or par_en_q.
REQ-014 load and ser_en SHALL never both be 1 in the same cycle. ser_en SHALL be 0 in every state other than DATA.
REQ-015 Frame length SHALL be DATA_WIDTH+2 cycles without parity and DATA_WIDTH+3 cycles with parity.
REQ-016 Changes to PAR_EN, PAR_TYP or P_DATA after acceptance SHALL NOT affect the frame in flight.
REQ-017 TX_OUT, load, ser_en and Busy SHALL be combinational functions of the state, ser_data, par_q and DATA_VALID only. ser_data SHALL be consumed only in DATA.

Reset
REQ-018 When RST=0 at a rising edge, the block SHALL set state to IDLE, par_q to 0 and par_en_q to 0.
REQ-019 After that reset edge, the outputs SHALL be TX_OUT=1, Busy=0, ser_en=0, and load=DATA_VALID & RST.
REQ-020 Reset mid-frame SHALL abort the frame at the next edge, and TX_OUT SHALL return to 1. No partial parity or stop bit SHALL be emitted.
REQ-021 RST=0 SHALL force load=0 combinationally, so that the serializer is not loaded during reset.

Verification
REQ-022 The bench SHALL pair the block with an 8-bit serializer model and cover these scenarios:
- P_DATA=0xA5, PAR_EN=0 -> TX_OUT over 10 cycles = 0,1,0,1,0,0,1,0,1,1; Busy high for 10 cycles; ser_en high for 8 cycles.
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> 11-cycle frame with parity bit 0; with PAR_TYP=1 -> parity bit 1.
- P_DATA=0x01, PAR_EN=1, PAR_TYP=0 -> parity bit 1; PAR_TYP toggled during DATA -> parity unchanged.
- DATA_VALID held high with 0x55 then 0x0F -> second START immediately follows first STOP; no cycle with TX_OUT=1 and Busy=0 between frames.
- DATA_VALID pulsed during DATA -> ignored; load stays 0 and the frame is unaltered.
- RST=0 during the 4th data bit -> next cycle TX_OUT=1, Busy=0, ser_en=0; a new 0xFF frame then transmits correctly.
